// File: rtl/ws2812b_pkg.sv
// Shared types and constants for the WS2812B pixel path (frame source and serializer).
package ws2812b_pkg;

  localparam int NLEDS_DEF     = 64;
  localparam int FRAME_DIV_DEF = 833_333;

  // Bit timing at 50 MHz, shared with the serializer
  localparam int T0H_CYC    = 20;
  localparam int T1H_CYC    = 40;
  localparam int TBIT_CYC   = 63;
  localparam int TRESET_CYC = 2_500;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_t;

  typedef enum logic [1:0] {IDLE, FETCH, SCALE, PRESENT} state_t;

  function automatic grb_t rgb_to_grb(input rgb_t c);
    grb_t o;
    o.g = c.g;
    o.r = c.r;
    o.b = c.b;
    return o;
  endfunction

endpackage

// File: rtl/ws2812b_pixel_ram.sv
// Frame buffer: NLEDS x 24 simple dual-port RAM, synchronous read, read-before-write.
module ws2812b_pixel_ram #(
  parameter  int NLEDS = 64,
  localparam int AW    = $clog2(NLEDS)
) (
  input  logic          CLOCK_50,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [23:0]   rd_data
);

  // Not reset: contents survive RESET_N and start at zero on configuration
  logic [23:0] mem [NLEDS] = '{default: '0};

  always @(posedge CLOCK_50) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ws2812b_frame_source.sv
// Streams the frame buffer as GRB pixels on every frame tick over valid/ready.
// Optional WS2812B_BRIGHTNESS_EN adds a SCALE stage applying the global brightness.
module ws2812b_frame_source
  import ws2812b_pkg::*;
#(
  parameter  int NLEDS     = NLEDS_DEF,
  parameter  int FRAME_DIV = FRAME_DIV_DEF,
  localparam int AW        = $clog2(NLEDS)
) (
  input  logic          CLOCK_50,
  input  logic          RESET_N,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  input  logic [7:0]    brightness,
  output logic          px_valid,
  input  logic          px_ready,
  output logic [23:0]   px_data,
  output logic          px_last,
  output logic          frame_start,
  output logic          busy,
  output logic          overrun
);

  localparam int            DW      = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DW-1:0] DIV_TOP = DW'(FRAME_DIV - 1);
  localparam logic [AW-1:0] LAST    = AW'(NLEDS - 1);

  logic [DW-1:0] div_cnt;
  logic          tick;
  state_t        state;
  logic [AW-1:0] idx;
  logic          pending;
  logic          fetch_ph;
  logic [23:0]   rd_data;

  assign tick = (div_cnt == DIV_TOP);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) div_cnt <= '0;
    else          div_cnt <= tick ? '0 : div_cnt + 1'b1;
  end

  ws2812b_pixel_ram #(.NLEDS(NLEDS)) u_ram (
    .CLOCK_50,
    .wr_en,
    .wr_addr,
    .wr_data,
    .rd_en   (state == FETCH && !fetch_ph),
    .rd_addr (idx),
    .rd_data
  );

`ifdef WS2812B_BRIGHTNESS_EN
  rgb_t raw;

  function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
    logic [16:0] p;
    p = 17'(c) * 17'({1'b0, b} + 9'd1);
    return 8'(p >> 8);
  endfunction
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
`endif

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      idx         <= '0;
      pending     <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
      frame_start <= 1'b0;
      px_valid    <= 1'b0;
      px_data     <= '0;
      px_last     <= 1'b0;
      fetch_ph    <= 1'b0;
`ifdef WS2812B_BRIGHTNESS_EN
      raw         <= '0;
`endif
    end else begin
      frame_start <= 1'b0;
      // Only one tick can wait; a second one while waiting is lost
      if (tick && busy) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end
      case (state)
        IDLE: if (tick || pending) begin
          frame_start <= 1'b1;
          busy        <= 1'b1;
          pending     <= 1'b0;
          idx         <= '0;
          fetch_ph    <= 1'b0;
          state       <= FETCH;
        end
        // Phase 0 issues the read, phase 1 sees the RAM output
        FETCH: begin
          fetch_ph <= ~fetch_ph;
          if (fetch_ph) begin
`ifdef WS2812B_BRIGHTNESS_EN
            raw      <= rd_data;
            state    <= SCALE;
`else
            px_data  <= rgb_to_grb(rd_data);
            px_valid <= 1'b1;
            px_last  <= (idx == LAST);
            state    <= PRESENT;
`endif
          end
        end
`ifdef WS2812B_BRIGHTNESS_EN
        SCALE: begin
          px_data  <= rgb_to_grb({scale8(raw.r, brightness), scale8(raw.g, brightness),
                                  scale8(raw.b, brightness)});
          px_valid <= 1'b1;
          px_last  <= (idx == LAST);
          state    <= PRESENT;
        end
`endif
        PRESENT: if (px_ready) begin
          px_valid <= 1'b0;
          px_last  <= 1'b0;
          if (idx == LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            idx   <= idx + 1'b1;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812b_frame_source.sv
// Scoreboard bench for ws2812b_frame_source: frames pushed at frame_start, popped on handshake.
module tb_ws2812b_frame_source;

  localparam int N   = 64;
  localparam int DIV = 200;
`ifdef WS2812B_BRIGHTNESS_EN
  localparam logic [23:0] BRI127 = 24'h204010;
  localparam logic        LAT3   = 1'b0;
`else
  localparam logic [23:0] BRI127 = 24'h408020;
  localparam logic        LAT3   = 1'b1;
`endif

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N  = 1'b1;
  logic        wr_en    = 1'b0;
  logic [5:0]  wr_addr  = '0;
  logic [23:0] wr_data  = '0;
  logic [7:0]  brightness = 8'd255;
  logic        px_ready = 1'b1;
  logic        px_valid, px_last, frame_start, busy, overrun;
  logic [23:0] px_data;

  always #5 CLOCK_50 = ~CLOCK_50;

  ws2812b_frame_source #(.NLEDS(N), .FRAME_DIV(DIV)) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET_N     (RESET_N),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .brightness  (brightness),
    .px_valid    (px_valid),
    .px_ready    (px_ready),
    .px_data     (px_data),
    .px_last     (px_last),
    .frame_start (frame_start),
    .busy        (busy),
    .overrun     (overrun)
  );

  int          tests = 0, fails = 0;
  int          frame_cnt = 0, hs_cnt = 0;
  logic [23:0] model [N];
  logic [24:0] q [$];
  logic [24:0] sb_e;
  logic        prev_stall = 1'b0;
  logic [24:0] prev_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] exp_grb(input logic [23:0] rgb);
    logic [7:0] r, g, b;
    r = rgb[23:16]; g = rgb[15:8]; b = rgb[7:0];
`ifdef WS2812B_BRIGHTNESS_EN
    r = 8'((int'(r) * (int'(brightness) + 1)) / 256);
    g = 8'((int'(g) * (int'(brightness) + 1)) / 256);
    b = 8'((int'(b) * (int'(brightness) + 1)) / 256);
`endif
    return {g, r, b};
  endfunction

  function automatic logic [23:0] pat(input int i);
    if (i == 0)  return 24'hFF0000;
    if (i == 63) return 24'h0000FF;
    if (i == 5)  return 24'h804020;
    return {8'(i * 4), 8'(8'hC3 ^ 8'(i)), 8'(255 - i)};
  endfunction

  // Monitor / scoreboard
  always @(negedge CLOCK_50) begin
    if (!RESET_N) prev_stall = 1'b0;
    else begin
      if (frame_start) begin
        chk("sb_empty_at_frame_start", q.size(), 0);
        for (int i = 0; i < N; i++) q.push_back({i == N - 1, model[i]});
        frame_cnt++;
        hs_cnt = 0;
      end
      if (prev_stall) begin
        chk("stall_valid", {31'b0, px_valid}, 1);
        chk("stall_hold", {7'b0, px_last, px_data}, {7'b0, prev_out});
      end
      prev_stall = px_valid && !px_ready;
      prev_out   = {px_last, px_data};
      if (px_valid && px_ready) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_pixel: got %h expected none", px_data);
        end else begin
          sb_e = q.pop_front();
          chk($sformatf("pixel f%0d i%0d", frame_cnt, hs_cnt), {7'b0, px_last, px_data},
              {7'b0, sb_e[24], exp_grb(sb_e[23:0])});
        end
        if (frame_cnt == 1 && hs_cnt == 0)  chk("first_grb", px_data, 24'h00FF00);
        if (frame_cnt == 1 && hs_cnt == 63) chk("last_grb", {px_last, px_data}, {1'b1, 24'h0000FF});
        if (frame_cnt == 3 && hs_cnt == 5)  chk("bri127", px_data, BRI127);
        if (frame_cnt == 4 && hs_cnt == 5)  chk("bri255", px_data, 24'h408020);
        hs_cnt++;
      end
    end
  end

  task automatic wr(input int a, input logic [23:0] d);
    @(posedge CLOCK_50); #1;
    wr_en = 1'b1; wr_addr = 6'(a); wr_data = d; model[a] = d;
    @(posedge CLOCK_50); #1;
    wr_en = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_px_valid"}, {31'b0, px_valid}, 0);
    chk({tag, "_px_data"}, {8'b0, px_data}, 0);
    chk({tag, "_px_last"}, {31'b0, px_last}, 0);
    chk({tag, "_frame_start"}, {31'b0, frame_start}, 0);
    chk({tag, "_busy"}, {31'b0, busy}, 0);
    chk({tag, "_overrun"}, {31'b0, overrun}, 0);
  endtask

  // Called at a negedge with RESET_N just released
  task automatic count_to_frame_start(input string name);
    int n = 0;
    bit seen = 1'b0;
    while (n < 1000 && !seen) begin
      @(posedge CLOCK_50); n++;
      @(negedge CLOCK_50); seen = frame_start;
    end
    chk(name, n, DIV);
  endtask

  task automatic wait_px(input int f, input int h, input string name);
    int n = 0;
    do begin
      @(posedge CLOCK_50); n++;
    end while (!(frame_cnt == f && hs_cnt == h) && n < 5000);
    if (n >= 5000) begin
      tests++; fails++;
      $display("FAIL timeout_%s: got no event expected frame %0d pixel %0d", name, f, h);
    end
    #1;
  endtask

  initial begin
    logic [24:0] cap;
    int k;
    #1 RESET_N = 1'b0;
    for (int i = 0; i < N; i++) wr(i, pat(i));
    @(negedge CLOCK_50);
    chk_reset_outs("reset");

    // Release and time the first tick
    @(negedge CLOCK_50); RESET_N = 1'b1;
    count_to_frame_start("first_frame_start_cycle");
    @(negedge CLOCK_50); chk("px_valid_T+2", {31'b0, px_valid}, 0);
    @(negedge CLOCK_50); chk("px_valid_T+3", {31'b0, px_valid}, {31'b0, LAT3});
    @(negedge CLOCK_50); chk("px_valid_T+4", {31'b0, px_valid}, {31'b0, ~LAT3});

    // Backpressure on pixel 5
    wait_px(1, 5, "bp");
    px_ready = 1'b0;
    k = 0;
    do begin @(negedge CLOCK_50); k++; end while (!px_valid && k < 20);
    cap = {px_last, px_data};
    repeat (50 - k) @(negedge CLOCK_50);
    chk("bp_valid", {31'b0, px_valid}, 1);
    chk("bp_hold", {7'b0, px_last, px_data}, {7'b0, cap});
    chk("bp_hs_cnt", hs_cnt, 5);
    @(posedge CLOCK_50); #1 px_ready = 1'b1;

    // Write LED3 in the cycle its read is issued
    wait_px(2, 3, "collision");
    wr_en = 1'b1; wr_addr = 6'd3; wr_data = 24'h123456; model[3] = 24'h123456;
    @(posedge CLOCK_50); #1 wr_en = 1'b0;

    wait_px(3, 0, "bri127");
    brightness = 8'd127;
    wait_px(4, 0, "bri255");
    brightness = 8'd255;

    // Stall a whole frame across several ticks
    wait_px(5, 0, "overrun");
    px_ready = 1'b0;
    chk("overrun_before", {31'b0, overrun}, 0);
    repeat (700) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("overrun_set", {31'b0, overrun}, 1);
    chk("overrun_busy", {31'b0, busy}, 1);
    chk("overrun_hs_cnt", hs_cnt, 0);
    @(posedge CLOCK_50); #1 px_ready = 1'b1;
    wait_px(7, 0, "overrun_sticky");
    chk("overrun_sticky", {31'b0, overrun}, 1);

    // Reset mid-frame
    wait_px(7, 10, "mid_reset");
    @(negedge CLOCK_50); #2 RESET_N = 1'b0;
    #1 chk_reset_outs("mid_reset");
    q.delete(); frame_cnt = 0; hs_cnt = 0;
    repeat (3) @(negedge CLOCK_50);
    RESET_N = 1'b1;
    count_to_frame_start("post_reset_frame_start_cycle");
    chk("post_reset_overrun", {31'b0, overrun}, 0);
    chk("post_reset_busy", {31'b0, busy}, 1);
    wait_px(1, 64, "post_reset_frame");
    @(negedge CLOCK_50);
    chk("sb_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
